// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: widths, default sizes and
// the internal opcode encodings produced by the decoder.
package alu_reservation_station_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int ROB_W_DEF   = 4;
    localparam int DATA_W      = 32;
    localparam int OPC_W       = 6;

    typedef enum logic [OPC_W-1:0] {
        OP_NONE = 6'd0,
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JALR
    } alu_op_e;

endpackage

// File: rtl/rs_priority_pick.sv
// Lowest-index priority picker: reports whether any request bit is set and
// the index of the lowest one.
module rs_priority_pick #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        found = 1'b0;
        idx   = '0;
        // Scanning downwards lets the lowest set bit win by being written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops until both operands are
// available (snooping both CDBs) and issues one ready op per cycle to the ALU.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROB_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear,

    input  logic                issue_sgn,
    input  logic [OPC_W-1:0]    issue_opcode,
    input  logic [ROB_W-1:0]    issue_ROB_name,
    input  logic [DATA_W-1:0]   issue_Vj,
    input  logic [DATA_W-1:0]   issue_Vk,
    input  logic                issue_Qj_busy,
    input  logic                issue_Qk_busy,
    input  logic [ROB_W-1:0]    issue_Qj,
    input  logic [ROB_W-1:0]    issue_Qk,

    input  logic                CDB_ALU_sgn,
    input  logic [ROB_W-1:0]    CDB_ALU_ROB_name,
    input  logic [DATA_W-1:0]   CDB_ALU_result,
    input  logic                CDB_LSB_sgn,
    input  logic [ROB_W-1:0]    CDB_LSB_ROB_name,
    input  logic [DATA_W-1:0]   CDB_LSB_result,

    output logic                full,
    output logic                ALU_sgn,
    output logic [OPC_W-1:0]    ALU_opcode,
    output logic [ROB_W-1:0]    ALU_ROB_name,
    output logic [DATA_W-1:0]   ALU_lhs,
    output logic [DATA_W-1:0]   ALU_rhs
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] busy_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;

    logic [OPC_W-1:0]   opcode_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_q    [RS_SIZE];
    logic [DATA_W-1:0]  vj_q     [RS_SIZE];
    logic [DATA_W-1:0]  vk_q     [RS_SIZE];
    logic [ROB_W-1:0]   qj_q     [RS_SIZE];
    logic [ROB_W-1:0]   qk_q     [RS_SIZE];
    logic [RS_SIZE-1:0] qj_busy_q;
    logic [RS_SIZE-1:0] qk_busy_q;

    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               disp_found;
    logic [IDX_W-1:0]   disp_idx;
    logic               do_issue;

    // Resolve a pending operand against both broadcast buses; ALU bus wins.
    // Returns {still_pending, value}.
    function automatic logic [DATA_W:0] resolve(
        input logic              pend,
        input logic [ROB_W-1:0]  tag,
        input logic [DATA_W-1:0] val
    );
        if (pend && CDB_ALU_sgn && (CDB_ALU_ROB_name == tag))
            return {1'b0, CDB_ALU_result};
        if (pend && CDB_LSB_sgn && (CDB_LSB_ROB_name == tag))
            return {1'b0, CDB_LSB_result};
        return {pend, val};
    endfunction

    assign full      = (count == CNT_W'(RS_SIZE));
    assign ready_vec = busy & ~qj_busy_q & ~qk_busy_q;
    assign do_issue  = issue_sgn && !full && free_found;

    rs_priority_pick #(.N(RS_SIZE), .W(IDX_W)) u_free_pick (
        .req   (~busy),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_priority_pick #(.N(RS_SIZE), .W(IDX_W)) u_ready_pick (
        .req   (ready_vec),
        .found (disp_found),
        .idx   (disp_idx)
    );

    // Issue always targets a free slot and dispatch a busy one, so they never collide.
    always_comb begin
        busy_nxt = busy;
        if (do_issue)
            busy_nxt[free_idx] = 1'b1;
        if (disp_found)
            busy_nxt[disp_idx] = 1'b0;
        count_nxt = count + CNT_W'(do_issue) - CNT_W'(disp_found);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= '0;
            count        <= '0;
            ALU_sgn      <= 1'b0;
            ALU_opcode   <= '0;
            ALU_ROB_name <= '0;
            ALU_lhs      <= '0;
            ALU_rhs      <= '0;
        end else if (rdy) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            if (clear) begin
                busy    <= '0;
                count   <= '0;
                ALU_sgn <= 1'b0;
            end else begin
                busy    <= busy_nxt;
                count   <= count_nxt;
                ALU_sgn <= disp_found;
                if (disp_found) begin
                    ALU_opcode   <= opcode_q[disp_idx];
                    ALU_ROB_name <= rob_q[disp_idx];
                    ALU_lhs      <= vj_q[disp_idx];
                    ALU_rhs      <= vk_q[disp_idx];
                end
            end
        end
    end

    // NOTE: entry payload is not reset; busy alone qualifies it, so the
    // storage can map onto plain flops or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (do_issue && (free_idx == IDX_W'(i))) begin
                    opcode_q[i]             <= issue_opcode;
                    rob_q[i]                <= issue_ROB_name;
                    qj_q[i]                 <= issue_Qj;
                    qk_q[i]                 <= issue_Qk;
                    {qj_busy_q[i], vj_q[i]} <= resolve(issue_Qj_busy, issue_Qj, issue_Vj);
                    {qk_busy_q[i], vk_q[i]} <= resolve(issue_Qk_busy, issue_Qk, issue_Vk);
                end else if (busy[i]) begin
                    {qj_busy_q[i], vj_q[i]} <= resolve(qj_busy_q[i], qj_q[i], vj_q[i]);
                    {qk_busy_q[i], vk_q[i]} <= resolve(qk_busy_q[i], qk_q[i], vk_q[i]);
                end
            end
        end
    end

    // The dispatcher must never present an op while the station is full.
    issue_when_full: assert property (
        @(posedge clk) disable iff (!rst) (rdy && issue_sgn) |-> !full
    );

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios plus a
// randomized run compared against an entry-table reference model.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        issue_sgn;
    logic [5:0]  issue_opcode;
    logic [3:0]  issue_ROB_name, issue_Qj, issue_Qk;
    logic [31:0] issue_Vj, issue_Vk;
    logic        issue_Qj_busy, issue_Qk_busy;
    logic        CDB_ALU_sgn, CDB_LSB_sgn;
    logic [3:0]  CDB_ALU_ROB_name, CDB_LSB_ROB_name;
    logic [31:0] CDB_ALU_result, CDB_LSB_result;
    logic        full, ALU_sgn;
    logic [5:0]  ALU_opcode;
    logic [3:0]  ALU_ROB_name;
    logic [31:0] ALU_lhs, ALU_rhs;

    int total = 0;
    int bad   = 0;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .issue_sgn(issue_sgn), .issue_opcode(issue_opcode), .issue_ROB_name(issue_ROB_name),
        .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
        .issue_Qj_busy(issue_Qj_busy), .issue_Qk_busy(issue_Qk_busy),
        .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
        .CDB_ALU_sgn(CDB_ALU_sgn), .CDB_ALU_ROB_name(CDB_ALU_ROB_name), .CDB_ALU_result(CDB_ALU_result),
        .CDB_LSB_sgn(CDB_LSB_sgn), .CDB_LSB_ROB_name(CDB_LSB_ROB_name), .CDB_LSB_result(CDB_LSB_result),
        .full(full), .ALU_sgn(ALU_sgn), .ALU_opcode(ALU_opcode), .ALU_ROB_name(ALU_ROB_name),
        .ALU_lhs(ALU_lhs), .ALU_rhs(ALU_rhs)
    );

    always #5 clk = ~clk;

    // Reference model: a table of waiting ops plus the last op handed to the ALU.
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [3:0]  rob;
        logic [31:0] vj, vk;
        bit          qjb, qkb;
        logic [3:0]  qj, qk;
    } ment_t;

    ment_t       m [16];
    logic        e_sgn;
    logic [5:0]  e_op;
    logic [3:0]  e_rob;
    logic [31:0] e_lhs, e_rhs;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m[i].busy) n++;
        return n;
    endfunction

    // A waiting operand takes a broadcast value whose tag it names (ALU bus first).
    function automatic void wake(inout bit pend, inout logic [31:0] v, input logic [3:0] q);
        if (!pend) return;
        if (CDB_ALU_sgn && CDB_ALU_ROB_name == q) begin
            v = CDB_ALU_result; pend = 0;
        end else if (CDB_LSB_sgn && CDB_LSB_ROB_name == q) begin
            v = CDB_LSB_result; pend = 0;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i].busy = 0;
        e_sgn = 0; e_op = '0; e_rob = '0; e_lhs = '0; e_rhs = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        ment_t nm [16];
        int    r = -1;
        int    f = -1;
        if (!rdy) return;
        nm = m;
        if (clear) begin
            for (int i = 0; i < 16; i++) nm[i].busy = 0;
            e_sgn = 0;
            m = nm;
            return;
        end
        for (int i = 15; i >= 0; i--) begin
            if (m[i].busy && !m[i].qjb && !m[i].qkb) r = i;
            if (!m[i].busy) f = i;
        end
        e_sgn = (r >= 0);
        if (r >= 0) begin
            e_op = m[r].op; e_rob = m[r].rob; e_lhs = m[r].vj; e_rhs = m[r].vk;
            nm[r].busy = 0;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy) begin
                wake(nm[i].qjb, nm[i].vj, nm[i].qj);
                wake(nm[i].qkb, nm[i].vk, nm[i].qk);
            end
        end
        if (issue_sgn && m_count() < 16) begin
            nm[f].busy = 1; nm[f].op = issue_opcode; nm[f].rob = issue_ROB_name;
            nm[f].vj = issue_Vj; nm[f].vk = issue_Vk;
            nm[f].qjb = issue_Qj_busy; nm[f].qkb = issue_Qk_busy;
            nm[f].qj = issue_Qj; nm[f].qk = issue_Qk;
            wake(nm[f].qjb, nm[f].vj, nm[f].qj);
            wake(nm[f].qkb, nm[f].vk, nm[f].qk);
        end
        m = nm;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; issue_sgn = 0; issue_opcode = '0; issue_ROB_name = '0;
        issue_Vj = '0; issue_Vk = '0; issue_Qj_busy = 0; issue_Qk_busy = 0;
        issue_Qj = '0; issue_Qk = '0;
        CDB_ALU_sgn = 0; CDB_ALU_ROB_name = '0; CDB_ALU_result = '0;
        CDB_LSB_sgn = 0; CDB_LSB_ROB_name = '0; CDB_LSB_result = '0;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [3:0] rob,
                               input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                               input logic [31:0] vk, input logic qkb, input logic [3:0] qk);
        issue_sgn = 1; issue_opcode = op; issue_ROB_name = rob;
        issue_Vj = vj; issue_Qj_busy = qjb; issue_Qj = qj;
        issue_Vk = vk; issue_Qk_busy = qkb; issue_Qk = qk;
    endtask

    function automatic logic [74:0] outs();
        return {ALU_sgn, ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs};
    endfunction

    task automatic test_reset();
        total++;
        if (outs() !== 75'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", outs());
        end
        total++;
        if (full !== 1'b0) begin
            bad++; $display("FAIL reset_full: got %b want 0", full);
        end
    endtask

    task automatic test_simple_add();
        drive_issue(OP_ADD, 4'd3, 32'd5, 0, 4'd0, 32'd7, 0, 4'd0);
        cycle();
        idle();
        total++;
        if (ALU_sgn !== 1'b0) begin
            bad++; $display("FAIL add_latency_early: got sgn=%b want 0", ALU_sgn);
        end
        cycle();
        total++;
        if (outs() !== {1'b1, OP_ADD, 4'd3, 32'd5, 32'd7}) begin
            bad++; $display("FAIL add_dispatch: got %h want %h", outs(), {1'b1, OP_ADD, 4'd3, 32'd5, 32'd7});
        end
        cycle();
        total++;
        if (ALU_sgn !== 1'b0) begin
            bad++; $display("FAIL add_pulse: got sgn=%b want 0", ALU_sgn);
        end
    endtask

    task automatic test_cdb_wakeup();
        logic early = 0;
        drive_issue(OP_SUB, 4'd2, 32'd0, 1, 4'd1, 32'd4, 0, 4'd0);
        cycle();
        idle();
        repeat (3) begin
            cycle();
            early |= ALU_sgn;
        end
        CDB_ALU_sgn = 1; CDB_ALU_ROB_name = 4'd1; CDB_ALU_result = 32'd10;
        cycle();
        idle();
        early |= ALU_sgn;
        total++;
        if (early !== 1'b0) begin
            bad++; $display("FAIL wakeup_early: got sgn=%b want 0", early);
        end
        cycle();
        total++;
        if (outs() !== {1'b1, OP_SUB, 4'd2, 32'd10, 32'd4}) begin
            bad++; $display("FAIL wakeup_dispatch: got %h want %h", outs(), {1'b1, OP_SUB, 4'd2, 32'd10, 32'd4});
        end
    endtask

    task automatic test_same_cycle_forward();
        drive_issue(OP_AND, 4'd5, 32'h11, 0, 4'd0, 32'd0, 1, 4'd6);
        CDB_LSB_sgn = 1; CDB_LSB_ROB_name = 4'd6; CDB_LSB_result = 32'hDEADBEEF;
        cycle();
        idle();
        cycle();
        total++;
        if (outs() !== {1'b1, OP_AND, 4'd5, 32'h11, 32'hDEADBEEF}) begin
            bad++; $display("FAIL forward_dispatch: got %h want %h", outs(), {1'b1, OP_AND, 4'd5, 32'h11, 32'hDEADBEEF});
        end
        cycle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive_issue(OP_ADD, 4'(i), 32'd0, 1, 4'd9, 32'(100 + i), 0, 4'd0);
            cycle();
        end
        idle();
        total++;
        if ({full, ALU_sgn} !== 2'b10) begin
            bad++; $display("FAIL fill_full: got full=%b sgn=%b want full=1 sgn=0", full, ALU_sgn);
        end
        CDB_ALU_sgn = 1; CDB_ALU_ROB_name = 4'd9; CDB_ALU_result = 32'h900;
        cycle();
        idle();
        total++;
        if ({full, ALU_sgn} !== 2'b10) begin
            bad++; $display("FAIL fill_wake_full: got full=%b sgn=%b want full=1 sgn=0", full, ALU_sgn);
        end
        for (int i = 0; i < 16; i++) begin
            cycle();
            total++;
            if (outs() !== {1'b1, OP_ADD, 4'(i), 32'h900, 32'(100 + i)}) begin
                bad++; $display("FAIL fill_drain_%0d: got %h want %h", i, outs(), {1'b1, OP_ADD, 4'(i), 32'h900, 32'(100 + i)});
            end
            total++;
            if (full !== 1'b0) begin
                bad++; $display("FAIL fill_full_drop_%0d: got %b want 0", i, full);
            end
        end
        cycle();
        total++;
        if (ALU_sgn !== 1'b0) begin
            bad++; $display("FAIL fill_empty: got sgn=%b want 0", ALU_sgn);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            drive_issue(OP_OR, 4'(8 + i), 32'd0, 1, 4'd5, 32'd1, 0, 4'd0);
            cycle();
        end
        idle();
        CDB_ALU_sgn = 1; CDB_ALU_ROB_name = 4'd5; CDB_ALU_result = 32'h55;
        cycle();
        idle();
        clear = 1;
        cycle();
        clear = 0;
        total++;
        if ({ALU_sgn, full} !== 2'b00) begin
            bad++; $display("FAIL clear_outputs: got sgn=%b full=%b want 0 0", ALU_sgn, full);
        end
        for (int i = 0; i < 16; i++) begin
            drive_issue(OP_XOR, 4'(i), 32'd0, 1, 4'd13, 32'(i), 0, 4'd0);
            cycle();
            if (i == 14) begin
                total++;
                if (full !== 1'b0) begin
                    bad++; $display("FAIL clear_count_15: got full=%b want 0", full);
                end
            end
        end
        idle();
        total++;
        if (full !== 1'b1) begin
            bad++; $display("FAIL clear_count_16: got full=%b want 1", full);
        end
        CDB_ALU_sgn = 1; CDB_ALU_ROB_name = 4'd13; CDB_ALU_result = 32'h1300;
        cycle();
        idle();
        cycle();
        total++;
        if (outs() !== {1'b1, OP_XOR, 4'd0, 32'h1300, 32'd0}) begin
            bad++; $display("FAIL clear_slot0: got %h want %h", outs(), {1'b1, OP_XOR, 4'd0, 32'h1300, 32'd0});
        end
        clear = 1;
        cycle();
        clear = 0;
        cycle();
        total++;
        if ({ALU_sgn, full} !== 2'b00) begin
            bad++; $display("FAIL clear_flush: got sgn=%b full=%b want 0 0", ALU_sgn, full);
        end
    endtask

    task automatic test_rdy_hold();
        logic held = 1;
        drive_issue(OP_SLT, 4'd4, 32'd1, 0, 4'd0, 32'd2, 0, 4'd0);
        cycle();
        drive_issue(OP_SLL, 4'd5, 32'd3, 0, 4'd0, 32'd4, 0, 4'd0);
        cycle();
        rdy = 0;
        drive_issue(OP_BEQ, 4'd6, 32'd8, 0, 4'd0, 32'd9, 0, 4'd0);
        repeat (3) begin
            cycle();
            if (outs() !== {1'b1, OP_SLT, 4'd4, 32'd1, 32'd2}) held = 0;
        end
        total++;
        if (held !== 1'b1) begin
            bad++; $display("FAIL rdy_hold: got %h want %h", outs(), {1'b1, OP_SLT, 4'd4, 32'd1, 32'd2});
        end
        rdy = 1;
        idle();
        cycle();
        total++;
        if (outs() !== {1'b1, OP_SLL, 4'd5, 32'd3, 32'd4}) begin
            bad++; $display("FAIL rdy_resume: got %h want %h", outs(), {1'b1, OP_SLL, 4'd5, 32'd3, 32'd4});
        end
        cycle();
        total++;
        if (ALU_sgn !== 1'b0) begin
            bad++; $display("FAIL rdy_no_ghost: got sgn=%b want 0", ALU_sgn);
        end
    endtask

    task automatic test_async_reset();
        logic stale = 0;
        for (int i = 1; i <= 4; i++) begin
            drive_issue(OP_JALR, 4'(i), 32'(i), 0, 4'd0, 32'(i), 0, 4'd0);
            cycle();
        end
        drive_issue(OP_BNE, 4'd7, 32'd0, 1, 4'd2, 32'd0, 0, 4'd0);
        cycle();
        idle();
        #3;
        rst = 0;
        model_reset();
        #1;
        total++;
        if ({outs(), full} !== 76'd0) begin
            bad++; $display("FAIL async_reset: got %h full=%b want 0", outs(), full);
        end
        @(posedge clk);
        #1;
        rst = 1;
        CDB_ALU_sgn = 1; CDB_ALU_ROB_name = 4'd2; CDB_ALU_result = 32'h2;
        cycle();
        idle();
        repeat (3) begin
            cycle();
            stale |= ALU_sgn;
        end
        total++;
        if (stale !== 1'b0) begin
            bad++; $display("FAIL reset_stale_dispatch: got sgn=%b want 0", stale);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy   = ($urandom_range(0, 7) != 0);
            clear = ($urandom_range(0, 79) == 0);
            if (m_count() < 16 && $urandom_range(0, 9) < 7)
                drive_issue(6'($urandom_range(1, 17)), 4'($urandom), $urandom,
                            1'($urandom), 4'($urandom_range(0, 7)),
                            $urandom, 1'($urandom), 4'($urandom_range(0, 7)));
            CDB_ALU_sgn = ($urandom_range(0, 9) < 4);
            CDB_ALU_ROB_name = 4'($urandom_range(0, 7));
            CDB_ALU_result = $urandom;
            CDB_LSB_sgn = ($urandom_range(0, 9) < 4);
            CDB_LSB_ROB_name = 4'($urandom_range(0, 7));
            CDB_LSB_result = $urandom;
            if (CDB_ALU_sgn && CDB_LSB_sgn && CDB_ALU_ROB_name == CDB_LSB_ROB_name)
                CDB_LSB_ROB_name = CDB_ALU_ROB_name ^ 4'd1;
            cycle();
            total++;
            if (outs() !== {e_sgn, e_op, e_rob, e_lhs, e_rhs}) begin
                bad++; $display("FAIL random_out_c%0d: got %h want %h", c, outs(), {e_sgn, e_op, e_rob, e_lhs, e_rhs});
            end
            total++;
            if (full !== (m_count() == 16)) begin
                bad++; $display("FAIL random_full_c%0d: got %b want %b", c, full, m_count() == 16);
            end
        end
        idle();
        rdy = 1;
    endtask

    initial begin
        rst = 0;
        rdy = 1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        test_reset();
        test_simple_add();
        test_cdb_wakeup();
        test_same_cycle_forward();
        test_fill();
        test_clear();
        test_rdy_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
